// File: rtl/uart_apb_poller.sv
// APB master that configures the UART receiver's register slave, then polls it for
// received bytes and hands each one downstream over a valid/ready handshake.
module uart_apb_poller #(
    parameter logic [13:0] BIT_PERIOD = 14'd10,
    parameter logic [3:0]  DATA_SIZE  = 4'd8,
    parameter int          POLL_GAP   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       cfg_start,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [2:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pslverr,
    output logic [7:0] rx_byte,
    output logic [1:0] rx_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       cfg_done,
    output logic       apb_err,
    output logic       busy
);

    localparam int CW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(POLL_GAP);

    // state    | meaning
    // S_IDLE   | unconfigured or stopped after an APB error
    // S_GAP    | inter-poll wait; decides poll / cfg when the counter runs out
    // S_SETUP  | APB setup phase of transfer op_q
    // S_ACCESS | APB access phase of transfer op_q
    // S_PUSH   | byte offered downstream, waiting for rx_ready
    typedef enum logic [2:0] {S_IDLE, S_GAP, S_SETUP, S_ACCESS, S_PUSH} state_t;
    typedef enum logic [2:0] {OP_W2, OP_W3, OP_W4, OP_STAT, OP_ERR, OP_DATA} op_t;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cfg_pend;
    logic           decide, end_seq, honor, set_done, err_hit;
    logic           cap_err, cap_data, set_valid, clr_valid;
    logic           xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_W2;
            cnt_q    <= '0;
            cfg_pend <= 1'b0;
            cfg_done <= 1'b0;
            apb_err  <= 1'b0;
            rx_valid <= 1'b0;
            rx_byte  <= 8'h00;
            rx_err   <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            if (honor)
                cfg_pend <= 1'b0;
            else if (cfg_start)
                cfg_pend <= 1'b1;
            if (err_hit)
                cfg_done <= 1'b0;
            else if (honor)
                cfg_done <= 1'b0;
            else if (set_done)
                cfg_done <= 1'b1;
            if (err_hit)
                apb_err <= 1'b1;
            else if (honor)
                apb_err <= 1'b0;
            if (set_valid)
                rx_valid <= 1'b1;
            else if (clr_valid)
                rx_valid <= 1'b0;
            if (cap_err)
                rx_err <= prdata[1:0];
            if (cap_data)
                rx_byte <= prdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        decide    = 1'b0;
        end_seq   = 1'b0;
        honor     = 1'b0;
        set_done  = 1'b0;
        err_hit   = 1'b0;
        cap_err   = 1'b0;
        cap_data  = 1'b0;
        set_valid = 1'b0;
        clr_valid = 1'b0;
        case (state_q)
            S_IDLE: decide = 1'b1;
            S_GAP: begin
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    cnt_d  = '0;
                    decide = 1'b1;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (pslverr) begin
                    err_hit = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    case (op_q)
                        OP_W2: begin
                            state_d = S_SETUP;
                            op_d    = OP_W3;
                        end
                        OP_W3: begin
                            state_d = S_SETUP;
                            op_d    = OP_W4;
                        end
                        OP_W4: begin
                            set_done = 1'b1;
                            state_d  = S_GAP;
                            cnt_d    = '0;
                        end
                        OP_STAT: begin
                            if (prdata[0]) begin
                                state_d = S_SETUP;
                                op_d    = OP_ERR;
                            end else begin
                                end_seq = 1'b1;
                            end
                        end
                        OP_ERR: begin
                            cap_err = 1'b1;
                            state_d = S_SETUP;
                            op_d    = OP_DATA;
                        end
                        OP_DATA: begin
                            cap_data  = 1'b1;
                            set_valid = 1'b1;
                            state_d   = S_PUSH;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_PUSH: begin
                if (rx_ready) begin
                    clr_valid = 1'b1;
                    end_seq   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A zero gap makes the end of a sequence itself the decision point.
        if (end_seq) begin
            if (POLL_GAP == 0) begin
                decide = 1'b1;
            end else begin
                state_d = S_GAP;
                cnt_d   = GAP_LOAD;
            end
        end

        if (decide) begin
            cnt_d = '0;
            if (cfg_pend || cfg_start) begin
                honor   = 1'b1;
                state_d = S_SETUP;
                op_d    = OP_W2;
            end else if (cfg_done && enable) begin
                state_d = S_SETUP;
                op_d    = OP_STAT;
            end else begin
                state_d = (state_q == S_IDLE) ? S_IDLE : S_GAP;
            end
        end
    end

    always_comb begin
        xfer    = (state_q == S_SETUP) || (state_q == S_ACCESS);
        psel    = xfer;
        penable = (state_q == S_ACCESS);
        busy    = !((state_q == S_IDLE) || (state_q == S_GAP));
        paddr   = 3'd0;
        pwrite  = 1'b0;
        pwdata  = 8'h00;
        if (xfer) begin
            case (op_q)
                OP_W2: begin
                    paddr  = 3'd2;
                    pwrite = 1'b1;
                    pwdata = BIT_PERIOD[7:0];
                end
                OP_W3: begin
                    paddr  = 3'd3;
                    pwrite = 1'b1;
                    pwdata = {2'b00, BIT_PERIOD[13:8]};
                end
                OP_W4: begin
                    paddr  = 3'd4;
                    pwrite = 1'b1;
                    pwdata = {4'b0000, DATA_SIZE};
                end
                OP_STAT: paddr = 3'd0;
                OP_ERR:  paddr = 3'd1;
                OP_DATA: paddr = 3'd6;
                default: paddr = 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_poller.sv
// Directed bench for uart_apb_poller: a small APB slave model, a bus logger and
// hand-computed transfer schedules.
module tb_uart_apb_poller;

    logic       clk = 1'b0;
    logic       rst, enable, cfg_start, rx_ready;
    logic       psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata;
    logic       pslverr;
    logic [7:0] rx_byte;
    logic [1:0] rx_err;
    logic       rx_valid, cfg_done, apb_err, busy;

    logic [7:0] stat_val, err_val, data_val;
    logic       inj;
    logic [2:0] err_addr;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int prot_bad = 0;
    int base, t;

    typedef struct {
        int         c;
        logic [2:0] a;
        logic       w;
        logic [7:0] d;
    } xfer_t;
    xfer_t q[$];

    logic       p_sel = 1'b0, p_en = 1'b0, p_w = 1'b0;
    logic [2:0] p_addr = 3'd0;
    logic [7:0] p_d = 8'h00;

    uart_apb_poller #(
        .BIT_PERIOD(14'h1A2B),
        .DATA_SIZE (4'd7),
        .POLL_GAP  (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .cfg_start(cfg_start),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pslverr  (pslverr),
        .rx_byte  (rx_byte),
        .rx_err   (rx_err),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .cfg_done (cfg_done),
        .apb_err  (apb_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Slave model: garbage outside ACCESS, error asserted from SETUP on to prove it is ignored there.
    assign prdata  = !(psel && penable) ? 8'hFF :
                     (paddr == 3'd0) ? stat_val :
                     (paddr == 3'd1) ? err_val :
                     (paddr == 3'd6) ? data_val : 8'h00;
    assign pslverr = inj && psel && (paddr == err_addr);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        xfer_t x;
        if (!rst) begin
            if (psel && penable) begin
                x.c = cyc;
                x.a = paddr;
                x.w = pwrite;
                x.d = pwdata;
                q.push_back(x);
            end
            if (penable && !psel) prot_bad++;
            if (!psel && (paddr != 3'd0 || pwdata != 8'h00 || pwrite)) prot_bad++;
            if (psel && penable && !(p_sel && !p_en && p_addr == paddr && p_w == pwrite && p_d == pwdata))
                prot_bad++;
            if (psel && !penable && p_sel && !p_en) prot_bad++;
            if (psel && !busy) prot_bad++;
        end
        p_sel  = psel;
        p_en   = penable;
        p_addr = paddr;
        p_w    = pwrite;
        p_d    = pwdata;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pk(input int rel, input logic w, input logic [2:0] a, input logic [7:0] d);
        return {16'(rel), 4'b0000, w, a, d};
    endfunction

    function automatic logic [31:0] entry(input int i, input int b);
        if (i >= q.size()) return 32'hFFFF_FFFF;
        return pk(q[i].c - b, q[i].w, q[i].a, q[i].d);
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_start = 1'b0; rx_ready = 1'b0;
        stat_val = 8'h00; err_val = 8'h00; data_val = 8'h00; inj = 1'b0; err_addr = 3'd3;
        repeat (2) @(negedge clk);
        chk("reset", 32'({psel, penable, pwrite, paddr, pwdata, rx_byte, rx_err,
                          rx_valid, cfg_done, apb_err, busy}), 32'd0);
        rst = 1'b0;
        cycles(2);
        chk("idle_after_reset", 32'({psel, busy, cfg_done}), 32'd0);

        // configuration sequence
        q.delete();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        base = cyc;
        chk("cfg_setup", 32'({psel, penable, pwrite, paddr, pwdata}), 32'({1'b1, 1'b0, 1'b1, 3'd2, 8'h2B}));
        wait_to(base + 5);
        chk("cfg_done_early", 32'(cfg_done), 32'd0);
        wait_to(base + 6);
        chk("cfg_done", 32'(cfg_done), 32'd1);
        cycles(10);
        chk("cfg_count", 32'(q.size()), 32'd3);
        chk("cfg_w2", entry(0, base), pk(1, 1'b1, 3'd2, 8'h2B));
        chk("cfg_w3", entry(1, base), pk(3, 1'b1, 3'd3, 8'h1A));
        chk("cfg_w4", entry(2, base), pk(5, 1'b1, 3'd4, 8'h07));

        // empty polls every 10 cycles
        q.delete();
        enable = 1'b1;
        t = cyc;
        cycles(35);
        chk("poll_count", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            chk("poll_stat", entry(i, t), pk(2 + 10 * i, 1'b0, 3'd0, 8'h00));
        chk("poll_no_valid", 32'(rx_valid), 32'd0);
        enable = 1'b0;
        cycles(15);

        // poll with data and back-pressure
        q.delete();
        stat_val = 8'h01; err_val = 8'h02; data_val = 8'hA5;
        enable = 1'b1;
        t = cyc;
        wait_to(t + 6);
        chk("push_not_yet", 32'(rx_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            wait_to(t + 7 + i);
            chk("push_hold", 32'({rx_valid, rx_err, rx_byte, busy}), 32'({1'b1, 2'b10, 8'hA5, 1'b1}));
            if (i == 5) rx_ready = 1'b1;
        end
        wait_to(t + 13);
        rx_ready = 1'b0;
        stat_val = 8'h00;
        chk("push_accept", 32'(rx_valid), 32'd0);
        wait_to(t + 23);
        enable = 1'b0;
        chk("push_count", 32'(q.size()), 32'd4);
        chk("push_stat", entry(0, t), pk(2, 1'b0, 3'd0, 8'h00));
        chk("push_err", entry(1, t), pk(4, 1'b0, 3'd1, 8'h00));
        chk("push_data", entry(2, t), pk(6, 1'b0, 3'd6, 8'h00));
        chk("push_next", entry(3, t), pk(22, 1'b0, 3'd0, 8'h00));
        cycles(12);

        // slave error on the addr-3 write
        q.delete();
        inj = 1'b1;
        enable = 1'b1;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        base = cyc;
        wait_to(base + 4);
        chk("err_state", 32'({apb_err, cfg_done, busy}), 32'({1'b1, 1'b0, 1'b0}));
        cycles(20);
        chk("err_count", 32'(q.size()), 32'd2);
        chk("err_w3", entry(1, base), pk(3, 1'b1, 3'd3, 8'h1A));
        chk("err_sticky", 32'({apb_err, cfg_done}), 32'({1'b1, 1'b0}));
        inj = 1'b0;
        q.delete();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        base = cyc;
        chk("recfg_clr", 32'(apb_err), 32'd0);
        wait_to(base + 6);
        chk("recfg_done", 32'(cfg_done), 32'd1);
        wait_to(base + 10);
        chk("recfg_count", 32'(q.size()), 32'd4);
        chk("recfg_w4", entry(2, base), pk(5, 1'b1, 3'd4, 8'h07));
        chk("recfg_poll", entry(3, base), pk(8, 1'b0, 3'd0, 8'h00));
        enable = 1'b0;
        cycles(15);

        // cfg_start during the ERR read
        q.delete();
        stat_val = 8'h01; err_val = 8'h01; data_val = 8'h3C;
        rx_ready = 1'b1;
        enable = 1'b1;
        t = cyc;
        wait_to(t + 3);
        cfg_start = 1'b1;
        wait_to(t + 4);
        cfg_start = 1'b0;
        stat_val = 8'h00;
        wait_to(t + 7);
        chk("mid_push", 32'({rx_valid, rx_err, rx_byte}), 32'({1'b1, 2'b01, 8'h3C}));
        wait_to(t + 18);
        chk("mid_cfg_clr", 32'(cfg_done), 32'd0);
        wait_to(t + 26);
        enable = 1'b0;
        chk("mid_count", 32'(q.size()), 32'd7);
        chk("mid_data", entry(2, t), pk(6, 1'b0, 3'd6, 8'h00));
        chk("mid_w2", entry(3, t), pk(17, 1'b1, 3'd2, 8'h2B));
        chk("mid_w3", entry(4, t), pk(19, 1'b1, 3'd3, 8'h1A));
        chk("mid_w4", entry(5, t), pk(21, 1'b1, 3'd4, 8'h07));
        chk("mid_poll", entry(6, t), pk(24, 1'b0, 3'd0, 8'h00));
        cycles(15);

        // reset during the DATA-read ACCESS
        q.delete();
        stat_val = 8'h01; err_val = 8'h00; data_val = 8'h5A;
        rx_ready = 1'b0;
        enable = 1'b1;
        t = cyc;
        wait_to(t + 5);
        @(posedge clk);
        #2;
        chk("pre_rst", 32'({psel, penable, paddr}), 32'({1'b1, 1'b1, 3'd6}));
        rst = 1'b1;
        #1;
        chk("rst_async", 32'({psel, penable, rx_valid, cfg_done, busy}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(20);
        chk("rst_quiet", 32'(q.size()), 32'd2);
        chk("rst_cfg", 32'({cfg_done, rx_valid, busy}), 32'd0);
        enable = 1'b0;

        chk("protocol", 32'(prot_bad), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_apb_poller.md
# uart_apb_poller

APB master sequencer that owns the APB bus of the UART receiver's register slave. After a configuration request it programs bit period and data size. While enabled it polls the data-status register, fetches error status and the received byte when data is pending, and hands each byte downstream over a valid/ready handshake. It sits between the UART receiver subsystem and the consuming logic, replacing software-driven register access.

## Interface
- BIT_PERIOD, 14'd10, value written to bit-period registers (addr 2 low byte, addr 3 high byte)
- DATA_SIZE, 4'd8, value written to data-size register (addr 4)
- POLL_GAP, 8, idle cycles between an empty status poll (or a completed push) and the next poll; 0 = back-to-back
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- enable  in  1  level; permits polling once configured
- cfg_start  in  1  pulse; request (re)configuration
- psel, penable, pwrite  out  1 each  APB control
- paddr  out  3  APB address
- pwdata  out  8  APB write data
- prdata  in  8  APB read data, sampled in ACCESS cycle
- pslverr  in  1  APB error, sampled in ACCESS cycle
- rx_byte  out  8  received byte
- rx_err  out  2  error status captured with the byte (bit1 overrun, bit0 framing)
- rx_valid  out  1  byte available
- rx_ready  in  1  consumer accepts byte
- cfg_done  out  1  level; configuration completed without error
- apb_err  out  1  sticky; pslverr seen
- busy  out  1  FSM not in IDLE or GAP

## Operation
- Reset values: psel, penable, pwrite, paddr, pwdata, rx_byte, rx_err, rx_valid, cfg_done, apb_err, busy all 0. FSM in IDLE. Gap counter 0. Pending-cfg flag 0.
- Every transfer takes two cycles:
  - SETUP: psel=1, penable=0.
  - ACCESS: psel=1, penable=1.
  - paddr, pwrite and pwdata hold constant across both cycles. There is no wait state.
  - Outside transfers, psel=penable=0 and paddr/pwdata/pwrite are 0.
- cfg_start sets a pending flag.
  - The flag is honored only in IDLE or GAP, i.e. at a sequence boundary, never mid-transfer and never while rx_valid=1.
  - Honoring it clears the pending flag, cfg_done and apb_err.
- CFG sequence: three writes, in order.
  - addr 2: pwdata = BIT_PERIOD[7:0]
  - addr 3: pwdata = {2'b0, BIT_PERIOD[13:8]}
  - addr 4: pwdata = {4'b0, DATA_SIZE}
  - On completion, cfg_done=1 and the FSM enters GAP with counter 0.
- Poll sequence: starts from GAP when counter=0, cfg_done=1, enable=1 and no cfg pending.
  - STAT: read addr 0.
  - If prdata[0]=0, load the counter with POLL_GAP and go to GAP.
  - If prdata[0]=1:
    - ERR: read addr 1; rx_err <= prdata[1:0].
    - DATA: read addr 6; rx_byte <= prdata.
    - PUSH: rx_valid=1.
- PUSH holds rx_byte, rx_err and rx_valid stable until a cycle with rx_ready=1. On that edge rx_valid drops, the counter loads POLL_GAP, and the FSM goes to GAP.
- GAP decrements the counter to 0, then starts a poll or honors cfg. With enable=0 or cfg_done=0 it stays in GAP/IDLE, which are equivalent idle states.
- Deasserting enable mid-sequence does not abort it. The sequence, including PUSH, completes, and no new poll starts.
- pslverr=1 in any ACCESS cycle:
  - sets apb_err and clears cfg_done;
  - discards captured data, so rx_valid is not raised;
  - sends the FSM to IDLE the next cycle.
  - Polling stays stopped until a successful cfg_start sequence.
- cfg_start and pslverr in the same cycle: the error is recorded and the pending flag is set, so reconfiguration follows from IDLE.

## Timing
- cfg_start seen high at edge 0 in IDLE:
  - write addr 2 SETUP at cycle 1, ACCESS at cycle 2;
  - addr 3 at cycles 3–4;
  - addr 4 at cycles 5–6;
  - cfg_done=1 from cycle 7.
- Poll with data (POLL_GAP=0, enable=1):
  - STAT at cycles 0–1;
  - ERR at cycles 2–3;
  - DATA at cycles 4–5;
  - rx_valid=1 from cycle 6.
- Earliest next STAT SETUP: with rx_ready=1 in cycle 6, STAT SETUP is at cycle 7 plus POLL_GAP.
- Empty poll: next STAT SETUP is POLL_GAP+1 cycles after the STAT ACCESS cycle.
- prdata and pslverr are sampled only when psel&penable; they are ignored otherwise.
- busy=1 in every SETUP, ACCESS and PUSH cycle.
- rst asserted at any time, including mid-ACCESS or during PUSH: all outputs go to their reset values immediately (asynchronous). The FSM restarts in IDLE with cfg_done=0.

## Test plan
- Reset then cfg_start (BIT_PERIOD=14'h1A2B, DATA_SIZE=7) -> writes (2,8'h2B), (3,8'h1A), (4,8'h07) in cycles 1–6; cfg_done=1 at cycle 7; no other bus activity.
- Configured, enable=1, status prdata=0, POLL_GAP=8 -> addr-0 reads repeat every 10 cycles; rx_valid stays 0.
- Status 8'h01, error 8'h02, data 8'hA5, rx_ready held 0 for 5 cycles -> rx_valid from cycle 6; rx_byte=A5 and rx_err=2'b10 stable for 6 cycles; no bus activity while held; next poll after the accept plus POLL_GAP.
- pslverr=1 on the addr-3 write ACCESS -> apb_err=1, cfg_done=0, no addr-4 write; enable=1 produces no polls until a new cfg_start, which clears apb_err and completes.
- cfg_start pulsed during the ERR read of a poll -> ERR, DATA and PUSH complete (byte delivered), then the CFG write sequence runs before any further poll.
- rst pulsed during the DATA-read ACCESS cycle -> psel/penable/rx_valid/cfg_done drop at once; no bus activity after release until cfg_start.
